// File: rtl/apb_pkg.sv
// Shared APB types and helpers for the APB register-file completer.
package apb_pkg;

   typedef logic [2:0] prot_t;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   // One byte lane of a strobed write: take the new byte only when its strobe is set.
   function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                             input logic [7:0] wdata,
                                             input logic       strb);
      return strb ? wdata : old_byte;
   endfunction

endpackage

// File: rtl/apb_regfile_slave.sv
// APB4 completer holding NoRegs strobed registers with wait states, PSLVERR on
// decode/read-only/privilege errors and per-register hardware load-in.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int unsigned             AddrWidth  = 32,
   parameter int unsigned             DataWidth  = 32,
   parameter int unsigned             NoRegs     = 8,
   parameter logic [AddrWidth-1:0]    BaseAddr   = '0,
   parameter int unsigned             WaitCycles = 0,
   parameter logic [NoRegs-1:0]       ReadOnly   = '0,
   parameter bit                      PrivOnly   = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [AddrWidth-1:0]        paddr_i,
   input  prot_t                       pprot_i,
   input  logic                        psel_i,
   input  logic                        penable_i,
   input  logic                        pwrite_i,
   input  logic [DataWidth-1:0]        pwdata_i,
   input  logic [DataWidth/8-1:0]      pstrb_i,
   output logic                        pready_o,
   output logic [DataWidth-1:0]        prdata_o,
   output logic                        pslverr_o,
   output logic [NoRegs*DataWidth-1:0] reg_q_o,
   input  logic [NoRegs*DataWidth-1:0] reg_d_i,
   input  logic [NoRegs-1:0]           reg_load_i
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned AlignBits = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = (NoRegs > 1) ? $clog2(NoRegs) : 1;
   localparam int unsigned CntWidth  = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
   localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'((1 << AlignBits) - 1);
   localparam logic [CntWidth-1:0]  CntInit   =
      CntWidth'((WaitCycles > 0) ? (WaitCycles - 1) : 0);

   state_e                 state_q, state_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic [IdxWidth-1:0]    idx_q, idx_d;
   logic                   err_q, err_d;
   logic                   write_q, write_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [StrbWidth-1:0]   strb_q, strb_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;
   logic [DataWidth-1:0]   prdata_q, prdata_d;
   logic [DataWidth-1:0]   regs_q [NoRegs];
   logic [DataWidth-1:0]   regs_d [NoRegs];
   logic                   commit;

   logic [AddrWidth-1:0]   off, off_idx;
   logic [IdxWidth-1:0]    dec_idx;
   logic                   dec_err, acc_err;
   logic                   unused_prot;

   assign off     = paddr_i - BaseAddr;
   assign off_idx = off >> AlignBits;
   assign dec_idx = off_idx[IdxWidth-1:0];
   assign dec_err = (paddr_i < BaseAddr) || (off_idx >= AddrWidth'(NoRegs)) ||
                    ((off & AlignMask) != '0);
   assign acc_err = dec_err || (pwrite_i && ReadOnly[dec_idx]) || (PrivOnly && !pprot_i[0]);
   assign unused_prot = ^pprot_i[2:1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      err_d     = err_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      commit    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               idx_d   = dec_idx;
               err_d   = acc_err;
               write_d = pwrite_i;
               wdata_d = pwdata_i;
               strb_d  = pstrb_i;
               if (WaitCycles == 0) begin
                  state_d   = DONE;
                  pready_d  = 1'b1;
                  pslverr_d = acc_err;
                  prdata_d  = (acc_err || pwrite_i) ? '0 : regs_q[dec_idx];
               end else begin
                  cnt_d   = CntInit;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d   = DONE;
               pready_d  = 1'b1;
               pslverr_d = err_q;
               prdata_d  = (err_q || write_q) ? '0 : regs_q[idx_q];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            // A master that drops psel during the ready cycle aborts the write.
            state_d = IDLE;
            commit  = psel_i && write_q && !err_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // APB commit is applied after the hardware load so it takes priority.
   always_comb begin
      for (int i = 0; i < NoRegs; i++) begin
         regs_d[i] = regs_q[i];
         if (reg_load_i[i]) regs_d[i] = reg_d_i[i*DataWidth +: DataWidth];
         if (commit && (idx_q == IdxWidth'(i))) begin
            for (int b = 0; b < StrbWidth; b++) begin
               regs_d[i][b*8 +: 8] = strb_merge(regs_q[i][b*8 +: 8], wdata_q[b*8 +: 8],
                                                strb_q[b]);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < NoRegs; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         for (int i = 0; i < NoRegs; i++) regs_q[i] <= regs_d[i];
      end
   end

   for (genvar g = 0; g < NoRegs; g++) begin : gen_reg_out
      assign reg_q_o[g*DataWidth +: DataWidth] = regs_q[g];
   end

   assign pready_o  = pready_q;
   assign pslverr_o = pslverr_q;
   assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: a zero-wait instance (regs 4,5 read-only) and a 3-wait privileged instance.
module tb_apb_regfile_slave;

   logic         clk, rst_n;
   logic [31:0]  paddr, pwdata;
   logic [2:0]   pprot;
   logic         psel0, psel1, penable, pwrite;
   logic [3:0]   pstrb;
   logic         pready0, pready1, pslverr0, pslverr1;
   logic [31:0]  prdata0, prdata1;
   logic [255:0] regq0, regq1, regd0, regd1;
   logic [7:0]   load0, load1;

   int vec = 0;
   int miscomp = 0;
   logic [31:0] rd;
   logic        er;
   int          cyc;

   apb_regfile_slave #(
      .WaitCycles(0), .ReadOnly(8'h30), .PrivOnly(1'b0)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pprot_i(pprot), .psel_i(psel0),
      .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0), .reg_q_o(regq0),
      .reg_d_i(regd0), .reg_load_i(load0)
   );

   apb_regfile_slave #(
      .WaitCycles(3), .ReadOnly(8'h00), .PrivOnly(1'b1)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pprot_i(pprot), .psel_i(psel1),
      .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready1), .prdata_o(prdata1), .pslverr_o(pslverr1), .reg_q_o(regq1),
      .reg_d_i(regd1), .reg_load_i(load1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] q0(input int i);
      return regq0[i*32 +: 32];
   endfunction

   function automatic logic [31:0] q1(input int i);
      return regq1[i*32 +: 32];
   endfunction

   // Called #1 after an edge; returns #1 after the edge that ends the transfer.
   task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                       input logic [7:0] ld, output logic [31:0] rdo, output logic ero,
                       output int cy);
      paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr; penable = 1'b0;
      if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      cy = 1;
      while (!((d == 0) ? pready0 : pready1) && cy < 20) begin
         @(posedge clk); #1;
         cy++;
      end
      rdo = (d == 0) ? prdata0 : prdata1;
      ero = (d == 0) ? pslverr0 : pslverr1;
      if (d == 0) load0 = ld; else load1 = ld;
      @(posedge clk); #1;
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; load0 = '0; load1 = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; paddr = '0; pprot = '0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      pwrite = 1'b0; pwdata = '0; pstrb = '0; regd0 = '0; regd1 = '0; load0 = '0; load1 = '0;
      #12;
      vec++; if (pready0 !== 1'b0 || pready1 !== 1'b0) begin
         miscomp++; $display("FAIL reset pready: got %b/%b want 0/0", pready0, pready1); end
      vec++; if (prdata0 !== 32'h0 || prdata1 !== 32'h0) begin
         miscomp++; $display("FAIL reset prdata: got %h/%h want 0", prdata0, prdata1); end
      vec++; if (pslverr0 !== 1'b0 || pslverr1 !== 1'b0) begin
         miscomp++; $display("FAIL reset pslverr: got %b/%b want 0", pslverr0, pslverr1); end
      vec++; if (regq0 !== 256'h0 || regq1 !== 256'h0) begin
         miscomp++; $display("FAIL reset regs: got %h / %h want 0", regq0, regq1); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      xfer(0, 32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b0 || cyc != 1) begin
         miscomp++; $display("FAIL wr0 resp: err %b cyc %0d want 0 1", er, cyc); end
      vec++; if (q0(2) !== 32'hDEADBEEF) begin
         miscomp++; $display("FAIL wr0 reg2: got %h want deadbeef", q0(2)); end
      xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || cyc != 1) begin
         miscomp++; $display("FAIL rd0 reg2: got %h err %b cyc %0d want deadbeef 0 1",
                             rd, er, cyc); end
   endtask

   task automatic test_wait_states();
      xfer(1, 32'h0, 1'b1, 32'h12345678, 4'hF, 3'b001, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b0 || cyc != 4) begin
         miscomp++; $display("FAIL wait wr: err %b cyc %0d want 0 4", er, cyc); end
      xfer(1, 32'h0, 1'b0, 32'h0, 4'h0, 3'b001, 8'h0, rd, er, cyc);
      vec++; if (rd !== 32'h12345678 || er !== 1'b0 || cyc != 4) begin
         miscomp++; $display("FAIL wait rd: got %h err %b cyc %0d want 12345678 0 4",
                             rd, er, cyc); end
      vec++; if (pready1 !== 1'b0 || prdata1 !== 32'h0) begin
         miscomp++; $display("FAIL wait pready width: got %b %h want 0 0", pready1, prdata1); end
   endtask

   task automatic test_strobes();
      xfer(0, 32'h4, 1'b1, 32'h11223344, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      xfer(0, 32'h4, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, 8'h0, rd, er, cyc);
      xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin
         miscomp++; $display("FAIL strb merge: got %h err %b want 11bb33dd 0", rd, er); end
      xfer(0, 32'h4, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b0 || q0(1) !== 32'h11BB33DD) begin
         miscomp++; $display("FAIL strb zero: err %b reg %h want 0 11bb33dd", er, q0(1)); end
   endtask

   task automatic test_errors();
      xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin
         miscomp++; $display("FAIL oob rd: err %b data %h want 1 0", er, rd); end
      xfer(0, 32'h6, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b1 || q0(1) !== 32'h11BB33DD) begin
         miscomp++; $display("FAIL unaligned wr: err %b reg1 %h want 1 11bb33dd", er, q0(1)); end
      xfer(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b1 || q0(4) !== 32'h0) begin
         miscomp++; $display("FAIL ro wr: err %b reg4 %h want 1 0", er, q0(4)); end
      xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b0) begin
         miscomp++; $display("FAIL ro rd: err %b want 0", er); end
      xfer(1, 32'h0, 1'b1, 32'hCAFECAFE, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b1 || q1(0) !== 32'h12345678) begin
         miscomp++; $display("FAIL priv wr: err %b reg0 %h want 1 12345678", er, q1(0)); end
      xfer(1, 32'h0, 1'b0, 32'h0, 4'h0, 3'b110, 8'h0, rd, er, cyc);
      vec++; if (er !== 1'b1 || rd !== 32'h0 || cyc != 4) begin
         miscomp++; $display("FAIL priv rd: err %b data %h cyc %0d want 1 0 4", er, rd, cyc); end
   endtask

   task automatic test_hw_load();
      regd0[3*32 +: 32] = 32'h55555555;
      xfer(0, 32'hC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 8'h08, rd, er, cyc);
      vec++; if (er !== 1'b0 || q0(3) !== 32'hCAFEF00D) begin
         miscomp++; $display("FAIL hw vs apb rw: err %b reg3 %h want 0 cafef00d", er, q0(3)); end
      regd0[4*32 +: 32] = 32'h0BADC0DE;
      xfer(0, 32'h10, 1'b1, 32'h12345678, 4'hF, 3'b000, 8'h10, rd, er, cyc);
      vec++; if (er !== 1'b1 || q0(4) !== 32'h0BADC0DE) begin
         miscomp++; $display("FAIL hw vs apb ro: err %b reg4 %h want 1 0badc0de", er, q0(4)); end
      regd0[5*32 +: 32] = 32'h77665544;
      load0 = 8'h20;
      @(posedge clk); #1 load0 = '0;
      vec++; if (q0(5) !== 32'h77665544 || q0(3) !== 32'hCAFEF00D) begin
         miscomp++; $display("FAIL hw load: reg5 %h reg3 %h want 77665544 cafef00d",
                             q0(5), q0(3)); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd2;
      logic        er2;
      int          cyc2;
      xfer(0, 32'h18, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, 8'h0, rd, er, cyc);
      xfer(0, 32'h18, 1'b0, 32'h0, 4'h0, 3'b000, 8'h0, rd2, er2, cyc2);
      vec++; if (rd2 !== 32'hA5A5A5A5 || er2 !== 1'b0 || cyc2 != 1 || cyc != 1) begin
         miscomp++; $display("FAIL b2b: data %h err %b cyc %0d/%0d want a5a5a5a5 0 1/1",
                             rd2, er2, cyc, cyc2); end
   endtask

   task automatic test_abort();
      paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hFFFF0000; pstrb = 4'hF; pprot = 3'b001;
      psel1 = 1'b1; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel1 = 1'b0; penable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      vec++; if (q1(1) !== 32'h0 || pready1 !== 1'b0) begin
         miscomp++; $display("FAIL abort: reg1 %h pready %b want 0 0", q1(1), pready1); end
      xfer(1, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, 8'h0, rd, er, cyc);
      vec++; if (rd !== 32'h0 || er !== 1'b0 || cyc != 4) begin
         miscomp++; $display("FAIL post abort: data %h err %b cyc %0d want 0 0 4", rd, er, cyc); end
   endtask

   task automatic test_reset_mid();
      paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hFEEDFACE; pstrb = 4'hF; pprot = 3'b001;
      psel1 = 1'b1; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      vec++; if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 32'h0) begin
         miscomp++; $display("FAIL mid rst outs: %b %b %h want 0 0 0", pready1, pslverr1, prdata1); end
      vec++; if (q1(0) !== 32'h0 || q0(2) !== 32'h0) begin
         miscomp++; $display("FAIL mid rst async: reg %h/%h want 0", q1(0), q0(2)); end
      psel1 = 1'b0; penable = 1'b0;
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec++; if (q1(2) !== 32'h0) begin
         miscomp++; $display("FAIL mid rst commit: reg2 %h want 0", q1(2)); end
      xfer(1, 32'h8, 1'b1, 32'h0F0F0F0F, 4'hF, 3'b001, 8'h0, rd, er, cyc);
      xfer(1, 32'h8, 1'b0, 32'h0, 4'h0, 3'b001, 8'h0, rd, er, cyc);
      vec++; if (rd !== 32'h0F0F0F0F || er !== 1'b0 || cyc != 4) begin
         miscomp++; $display("FAIL after rst: data %h err %b cyc %0d want 0f0f0f0f 0 4",
                             rd, er, cyc); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_strobes();
      test_errors();
      test_hw_load();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
      $finish;
   end

endmodule
